// File: rtl/collector.sv
// Reassembles the 7-beat diagonally skewed 4-lane stream into a held 4x4 matrix of 32-bit words.
// Start-to-done takes at least 8 edges, and each in_valid=0 cycle in COLLECT adds one edge.
module collector (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [31:0] d1,
  input  logic [31:0] d2,
  input  logic [31:0] d3,
  input  logic [31:0] d4,
  output logic        busy,
  output logic        done,
  output logic [31:0] c11,
  output logic [31:0] c12,
  output logic [31:0] c13,
  output logic [31:0] c14,
  output logic [31:0] c21,
  output logic [31:0] c22,
  output logic [31:0] c23,
  output logic [31:0] c24,
  output logic [31:0] c31,
  output logic [31:0] c32,
  output logic [31:0] c33,
  output logic [31:0] c34,
  output logic [31:0] c41,
  output logic [31:0] c42,
  output logic [31:0] c43,
  output logic [31:0] c44
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  beat;
  logic        take_start;
  logic        accept;
  logic        last_beat;
  logic [31:0] lane   [4];
  logic [31:0] mat    [4][4];
  logic        wr_en  [4][4];

  assign lane[0] = d1;
  assign lane[1] = d2;
  assign lane[2] = d3;
  assign lane[3] = d4;

  assign take_start = start && ((state == IDLE) || (state == DONE));
  assign accept     = (state == COLLECT) && in_valid;
  assign last_beat  = accept && (beat == 3'd6);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take_start) state_nxt = COLLECT;
      COLLECT: if (last_beat)  state_nxt = DONE;
      DONE:    state_nxt = take_start ? COLLECT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == COLLECT);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat <= 3'd0;
    end else if (take_start) begin
      beat <= 3'd0;
    end else if (accept) begin
      beat <= beat + 3'd1;
    end
  end

  // Lane j carries row r at beat r+j; every other beat on that lane is outside its window.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 4; j++) begin
        wr_en[r][j] = accept && (beat == 3'(r + j));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || take_start) begin
      for (int r = 0; r < 4; r++) begin
        for (int j = 0; j < 4; j++) begin
          mat[r][j] <= 32'd0;
        end
      end
    end else begin
      for (int r = 0; r < 4; r++) begin
        for (int j = 0; j < 4; j++) begin
          if (wr_en[r][j]) begin
            mat[r][j] <= lane[j];
          end
        end
      end
    end
  end

  assign c11 = mat[0][0];
  assign c12 = mat[0][1];
  assign c13 = mat[0][2];
  assign c14 = mat[0][3];
  assign c21 = mat[1][0];
  assign c22 = mat[1][1];
  assign c23 = mat[1][2];
  assign c24 = mat[1][3];
  assign c31 = mat[2][0];
  assign c32 = mat[2][1];
  assign c33 = mat[2][2];
  assign c34 = mat[2][3];
  assign c41 = mat[3][0];
  assign c42 = mat[3][1];
  assign c43 = mat[3][2];
  assign c44 = mat[3][3];

endmodule

// File: tb/tb_collector.sv
// Directed bench for collector: each start pushes the expected matrix and latency into a queue,
// and a monitor pops and compares whenever done is presented.
module tb_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [31:0] d1, d2, d3, d4;
  logic        busy, done;
  logic [31:0] c11, c12, c13, c14, c21, c22, c23, c24;
  logic [31:0] c31, c32, c33, c34, c41, c42, c43, c44;
  logic [31:0] cm [16];

  typedef struct {
    logic [31:0] base;
    int          lat;
    int          t0;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  logic prev_done = 1'b0;

  collector dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .d1(d1), .d2(d2), .d3(d3), .d4(d4),
    .busy(busy), .done(done),
    .c11(c11), .c12(c12), .c13(c13), .c14(c14),
    .c21(c21), .c22(c22), .c23(c23), .c24(c24),
    .c31(c31), .c32(c32), .c33(c33), .c34(c34),
    .c41(c41), .c42(c42), .c43(c43), .c44(c44)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    cm[0]  = c11; cm[1]  = c12; cm[2]  = c13; cm[3]  = c14;
    cm[4]  = c21; cm[5]  = c22; cm[6]  = c23; cm[7]  = c24;
    cm[8]  = c31; cm[9]  = c32; cm[10] = c33; cm[11] = c34;
    cm[12] = c41; cm[13] = c42; cm[14] = c43; cm[15] = c44;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic chk_matrix(input string nm, input logic [31:0] base, input logic zero);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("%s[%0d]", nm, i), cm[i], zero ? 32'd0 : base + 32'(i));
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      chk("done_single_cycle", {31'd0, prev_done}, 32'd0);
      chk("busy_low_at_done", {31'd0, busy}, 32'd0);
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done=1 at cycle %0d, expected no done", cyc);
      end else begin
        e = sbq.pop_front();
        chk("start_to_done_edges", 32'(cyc - e.t0), 32'(e.lat));
        chk_matrix("matrix", e.base, 1'b0);
      end
    end
    prev_done = done;
  end

  // Lane j (0-based) carries row t-j of the stream at beat t; outside that window it gets fill.
  task automatic drive_beat(input int t, input logic [31:0] base, input logic [31:0] fill,
                            input logic st);
    logic [31:0] v [4];
    for (int j = 0; j < 4; j++) begin
      int r;
      r = t - j;
      v[j] = (r >= 0 && r <= 3) ? base + 32'(4 * r + j) : fill;
    end
    start    = st;
    in_valid = 1'b1;
    d1 = v[0]; d2 = v[1]; d3 = v[2]; d4 = v[3];
  endtask

  task automatic send_beat(input int t, input logic [31:0] base, input logic [31:0] fill,
                           input logic st);
    @(negedge clk);
    drive_beat(t, base, fill, st);
  endtask

  task automatic stall(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b0;
    end
  endtask

  task automatic do_start(input logic [31:0] base, input int lat, input logic push);
    exp_t e;
    @(negedge clk);
    start    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    e.base = base;
    e.lat  = lat;
    e.t0   = cyc;
    if (push) sbq.push_back(e);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b0;
      n++;
    end while (!done && n < 40);
    chk("done_seen", {31'd0, done}, 32'd1);
    @(negedge clk);
    chk("busy_after_done", {31'd0, busy}, 32'd0);
    chk("done_after_done", {31'd0, done}, 32'd0);
  endtask

  initial begin
    int ndone;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    d1 = '0; d2 = '0; d3 = '0; d4 = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk_matrix("reset_c", 32'd0, 1'b1);
    rst = 1'b0;

    // Basic collect, out-of-window lanes zero.
    do_start(32'h0, 8, 1'b1);
    for (int t = 0; t < 7; t++) send_beat(t, 32'h0, 32'h0, 1'b0);
    wait_done();

    // Out-of-window lanes carry junk.
    do_start(32'h0, 8, 1'b1);
    for (int t = 0; t < 7; t++) send_beat(t, 32'h0, 32'hDEADBEEF, 1'b0);
    wait_done();

    // Stalls: 3 cycles between beats 2 and 3, 1 cycle before beat 6.
    do_start(32'h0, 12, 1'b1);
    for (int t = 0; t < 7; t++) begin
      if (t == 3) stall(3);
      if (t == 6) stall(1);
      send_beat(t, 32'h0, 32'h0, 1'b0);
    end
    wait_done();

    // Start pulsed mid-collection is ignored; start held in DONE chains the next collection.
    do_start(32'h0, 8, 1'b1);
    for (int t = 0; t < 7; t++) send_beat(t, 32'h0, 32'h0, t == 3);
    do_start(32'h100, 8, 1'b1);
    @(negedge clk);
    chk_matrix("cleared_on_start", 32'd0, 1'b1);
    chk("busy_after_restart", {31'd0, busy}, 32'd1);
    drive_beat(0, 32'h100, 32'h0, 1'b0);
    for (int t = 1; t < 7; t++) send_beat(t, 32'h100, 32'h0, 1'b0);
    wait_done();

    // Reset after beat 4 discards the partial matrix.
    do_start(32'h0, 8, 1'b0);
    for (int t = 0; t < 5; t++) send_beat(t, 32'h300, 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk_matrix("rst_mid_c", 32'd0, 1'b1);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_done", {31'd0, done}, 32'd0);
    ndone = 0;
    for (int t = 5; t < 12; t++) begin
      send_beat(t > 6 ? 6 : t, 32'h300, 32'h0, 1'b0);
      if (done) ndone++;
    end
    stall(3);
    if (done) ndone++;
    chk("no_done_after_rst", 32'(ndone), 32'd0);
    do_start(32'h40, 8, 1'b1);
    for (int t = 0; t < 7; t++) send_beat(t, 32'h40, 32'h0, 1'b0);
    wait_done();

    // Idle hold: random lanes with in_valid=1 and no start.
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("hold_busy", {31'd0, busy}, 32'd0);
      chk("hold_done", {31'd0, done}, 32'd0);
      start = 1'b0; in_valid = 1'b1;
      d1 = $urandom; d2 = $urandom; d3 = $urandom; d4 = $urandom;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk_matrix("hold_c", 32'h40, 1'b0);
    chk("hold_busy_end", {31'd0, busy}, 32'd0);
    chk("queue_drained", 32'(sbq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
